// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP sequencer.
package mmcm_drp_pkg;

    localparam int DRP_ADDR_W       = 7;
    localparam int DRP_DATA_W       = 16;
    localparam int DEF_DRDY_TIMEOUT = 255;
    localparam int DEF_LOCK_TIMEOUT = 65535;
    // The wait counter loads 1 on state entry, so LOCKED is trusted from the
    // third LOCK_WAIT cycle, i.e. two cycles after the sequencer reset fell.
    localparam int LOCK_SETTLE      = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        LOCK_WAIT
    } drp_seq_state_t;

    typedef struct packed {
        logic                  we;
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] din;
        logic [DRP_DATA_W-1:0] mask;
    } drp_req_t;

    // mask bit 1 keeps the current register bit, 0 takes the new data bit
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(
        input logic [DRP_DATA_W-1:0] cur,
        input logic [DRP_DATA_W-1:0] din,
        input logic [DRP_DATA_W-1:0] mask
    );
        return (cur & mask) | (din & ~mask);
    endfunction

endpackage

// File: rtl/drp_timeout_ctr.sv
// Loadable up-counter with clear and compare-equal, shared by the DRP wait states.
module drp_timeout_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] cmp,
    output logic [W-1:0] count,
    output logic         eq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (ld)
            count <= ld_val;
        else
            count <= count + W'(1);
    end

    assign eq = (count == cmp);

endmodule

// File: rtl/mmcm_drp_seq.sv
// Turns single-cycle register requests into DRP read / masked read-modify-write
// transactions, holding the MMCM in reset across writes until it relocks.
module mmcm_drp_seq
    import mmcm_drp_pkg::*;
#(
    parameter int pDRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
    parameter int pLOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int pCTR_W        = 16
) (
    input  logic                  clk_usb,
    input  logic                  reset_n,
    input  logic                  req_en,
    input  logic                  req_we,
    input  logic [DRP_ADDR_W-1:0] req_addr,
    input  logic [DRP_DATA_W-1:0] req_din,
    input  logic [DRP_DATA_W-1:0] req_mask,
    input  logic                  rst_hold,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  done,
    output logic [DRP_DATA_W-1:0] rdata,
    output logic                  err_timeout,
    output logic                  err_lock,
    output logic                  err_overrun,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic                  den,
    output logic                  dwe,
    output logic [DRP_DATA_W-1:0] di,
    input  logic [DRP_DATA_W-1:0] do_i,
    input  logic                  drdy,
    output logic                  mmcm_rst,
    input  logic                  locked
);

    localparam logic [pCTR_W-1:0] DRDY_CMP   = pCTR_W'(pDRDY_TIMEOUT);
    localparam logic [pCTR_W-1:0] LOCK_CMP   = pCTR_W'(pLOCK_TIMEOUT);
    localparam logic [pCTR_W-1:0] SETTLE_CNT = pCTR_W'(LOCK_SETTLE);

    drp_seq_state_t    state, next_state;
    drp_req_t          req_q;
    logic              rst_seq, rst_seq_d;
    logic [pCTR_W-1:0] ctr_count, ctr_cmp;
    logic              ctr_eq, lock_ok, in_drdy_wait;
    logic              den_d, dwe_d, busy_d, done_d;
    logic              set_to, set_lk, set_ov, cap_rd;

    assign ctr_cmp      = (state == LOCK_WAIT) ? LOCK_CMP : DRDY_CMP;
    assign lock_ok      = locked && (ctr_count >= SETTLE_CNT);
    assign in_drdy_wait = (state == RD_WAIT) || (state == WR_WAIT);

    // Every state entry restarts the count at 1; IDLE holds it at zero.
    drp_timeout_ctr #(.W(pCTR_W)) u_ctr (
        .clk    (clk_usb),
        .rst_n  (reset_n),
        .clr    (next_state == IDLE),
        .ld     (next_state != state),
        .ld_val (pCTR_W'(1)),
        .cmp    (ctr_cmp),
        .count  (ctr_count),
        .eq     (ctr_eq)
    );

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req_en) next_state = RD;
            RD:        next_state = RD_WAIT;
            RD_WAIT:   if (drdy) next_state = req_q.we ? WR : IDLE;
                       else if (ctr_eq) next_state = IDLE;
            WR:        next_state = WR_WAIT;
            WR_WAIT:   if (drdy) next_state = LOCK_WAIT;
                       else if (ctr_eq) next_state = IDLE;
            LOCK_WAIT: if (lock_ok || ctr_eq) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        den_d     = (next_state == RD) || (next_state == WR);
        dwe_d     = (next_state == WR);
        busy_d    = (next_state != IDLE);
        done_d    = (state != IDLE) && (next_state == IDLE);
        set_to    = in_drdy_wait && !drdy && ctr_eq;
        set_lk    = (state == LOCK_WAIT) && !lock_ok && ctr_eq;
        set_ov    = req_en && (state != IDLE);
        cap_rd    = (state == RD_WAIT) && drdy;
        rst_seq_d = rst_seq;
        if (next_state == WR)
            rst_seq_d = 1'b1;
        else if (state == WR_WAIT && next_state != WR_WAIT)
            rst_seq_d = 1'b0;
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            req_q       <= '0;
            den         <= 1'b0;
            dwe         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rst_seq     <= 1'b0;
            rdata       <= '0;
            di          <= '0;
            err_timeout <= 1'b0;
            err_lock    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (state == IDLE && req_en)
                req_q <= '{we: req_we, addr: req_addr, din: req_din, mask: req_mask};
            den     <= den_d;
            dwe     <= dwe_d;
            busy    <= busy_d;
            done    <= done_d;
            rst_seq <= rst_seq_d;
            if (cap_rd) begin
                rdata <= do_i;
                if (req_q.we)
                    di <= rmw_merge(do_i, req_q.din, req_q.mask);
            end
            err_timeout <= set_to | (err_timeout & ~clr_err);
            err_lock    <= set_lk | (err_lock & ~clr_err);
            err_overrun <= set_ov | (err_overrun & ~clr_err);
        end
    end

    assign daddr    = req_q.addr;
    assign mmcm_rst = rst_hold | rst_seq;

endmodule

// File: tb/tb_mmcm_drp_seq.sv
// Bench for mmcm_drp_seq: a per-transaction timeline model predicts every output each cycle.
module tb_mmcm_drp_seq;

    logic        clk_usb = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_en = 1'b0, req_we = 1'b0, rst_hold = 1'b0, clr_err = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_din = '0, req_mask = '0, do_i = '0;
    logic        drdy = 1'b0, locked = 1'b1;
    logic        busy, done, err_timeout, err_lock, err_overrun, den, dwe, mmcm_rst;
    logic [15:0] rdata, di;
    logic [6:0]  daddr;

    always #5 clk_usb = ~clk_usb;

    mmcm_drp_seq dut (
        .clk_usb(clk_usb), .reset_n(reset_n), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .req_mask(req_mask), .rst_hold(rst_hold),
        .clr_err(clr_err), .busy(busy), .done(done), .rdata(rdata),
        .err_timeout(err_timeout), .err_lock(err_lock), .err_overrun(err_overrun),
        .daddr(daddr), .den(den), .dwe(dwe), .di(di), .do_i(do_i), .drdy(drdy),
        .mmcm_rst(mmcm_rst), .locked(locked)
    );

    int n_vec = 0, n_err = 0;
    int k_now = -1, done_seen_k = -1;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle, and the model's registered state
    logic        e_busy, e_done, e_den, e_dwe, e_rst;
    logic [15:0] e_rdata, e_di;
    logic [6:0]  e_daddr;
    logic        e_to, e_lk, e_ov;
    logic        m_to, m_lk, m_ov;
    logic [15:0] m_rdata, m_di;
    logic [6:0]  m_daddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_to = 0; m_lk = 0; m_ov = 0; m_rdata = '0; m_di = '0; m_daddr = '0;
    endtask

    task automatic pull_model();
        e_rdata = m_rdata; e_di = m_di; e_daddr = m_daddr;
        e_to = m_to; e_lk = m_lk; e_ov = m_ov;
    endtask

    task automatic set_idle_exp();
        e_busy = 0; e_done = 0; e_den = 0; e_dwe = 0; e_rst = rst_hold;
        pull_model();
    endtask

    always @(negedge clk_usb) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("den", 32'(den), 32'(e_den));
            chk("dwe", 32'(dwe), 32'(e_dwe));
            chk("mmcm_rst", 32'(mmcm_rst), 32'(e_rst));
            chk("rdata", 32'(rdata), 32'(e_rdata));
            chk("di", 32'(di), 32'(e_di));
            chk("daddr", 32'(daddr), 32'(e_daddr));
            chk("err_timeout", 32'(err_timeout), 32'(e_to));
            chk("err_lock", 32'(err_lock), 32'(e_lk));
            chk("err_overrun", 32'(err_overrun), 32'(e_ov));
            if (done) done_seen_k = k_now;
        end
    end

    task automatic idle(input int n, input bit force_clr);
        for (int i = 0; i < n; i++) begin
            k_now   = -1;
            req_en  = 0;
            drdy    = ($urandom_range(0, 3) == 0);
            do_i    = 16'($urandom);
            locked  = 1;
            clr_err = (force_clr && i == 0) || ($urandom_range(0, 5) == 0);
            set_idle_exp();
            @(posedge clk_usb); #1;
            if (clr_err) begin m_to = 0; m_lk = 0; m_ov = 0; end
        end
        clr_err = 0;
        drdy    = 0;
    endtask

    // Cycle k=0 carries req_en; rd_n / wr_n are cycles from den to drdy (0 = never),
    // lock_j is the LOCK_WAIT cycle in which locked rises; -1 disables ovr_k/clr_k/abort_k.
    task automatic run_txn(input logic we, input logic [6:0] addr, input logic [15:0] din,
                           input logic [15:0] mask, input logic [15:0] rd_do,
                           input int rd_n, input int wr_n, input int lock_j,
                           input int ovr_k, input int clr_k, input int abort_k);
        bit rd_ok, wr_path, wr_ok, lock_ok, set_to, set_lk;
        bit rd_hit, wr_hit, noise_ok;
        int kr, l0, rst_fall, lk, dn;
        rd_ok    = (rd_n >= 1) && (rd_n <= 255);
        kr       = rd_ok ? 2 + rd_n : 257;
        wr_path  = we && rd_ok;
        wr_ok    = (wr_n >= 1) && (wr_n <= 255);
        l0       = kr + wr_n + 1;
        rst_fall = wr_ok ? l0 : kr + 256;
        lk       = (lock_j < 2) ? 2 : lock_j;
        lock_ok  = (lk <= 65534);
        if (!wr_path)    dn = kr;
        else if (!wr_ok) dn = kr + 256;
        else             dn = l0 + (lock_ok ? lk : 65534) + 1;
        set_to = !rd_ok || (wr_path && !wr_ok);
        set_lk = wr_path && wr_ok && !lock_ok;
        for (int k = 0; k <= dn; k++) begin
            if (k == abort_k) begin
                chk_en  = 0;
                reset_n = 0;
                #2;
                chk("arst_busy", 32'(busy), 0);
                chk("arst_den", 32'(den), 0);
                chk("arst_dwe", 32'(dwe), 0);
                chk("arst_di", 32'(di), 0);
                chk("arst_rdata", 32'(rdata), 0);
                chk("arst_daddr", 32'(daddr), 0);
                chk("arst_mmcm_rst", 32'(mmcm_rst), 32'(rst_hold));
                model_reset();
                req_en = 0; drdy = 0; clr_err = 0; locked = 1;
                @(posedge clk_usb); #1;
                reset_n = 1;
                set_idle_exp();
                chk_en = 1;
                k_now  = -1;
                return;
            end
            k_now    = k;
            rd_hit   = rd_ok && (k == 1 + rd_n);
            wr_hit   = wr_path && wr_ok && (k == kr + wr_n);
            noise_ok = (k <= 1) || (k >= dn) || (wr_path && (k == kr || (wr_ok && k >= l0)));
            req_en   = (k == 0) || (k == ovr_k && ovr_k < dn);
            req_we   = (k == 0) ? we : 1'($urandom);
            req_addr = (k == 0) ? addr : 7'($urandom);
            req_din  = (k == 0) ? din : 16'($urandom);
            req_mask = (k == 0) ? mask : 16'($urandom);
            drdy     = rd_hit || wr_hit || (noise_ok && $urandom_range(0, 3) == 0);
            do_i     = rd_hit ? rd_do : 16'($urandom);
            locked   = !(wr_path && k >= kr && k < l0 + lock_j);
            clr_err  = (k == clr_k);
            e_busy   = (k >= 1) && (k < dn);
            e_done   = (k == dn);
            e_den    = (k == 1) || (wr_path && k == kr);
            e_dwe    = wr_path && (k == kr);
            e_rst    = rst_hold | (wr_path && k >= kr && k < rst_fall);
            pull_model();
            @(posedge clk_usb); #1;
            if (k == 0) m_daddr = addr;
            if (rd_ok && k == kr - 1) begin
                m_rdata = rd_do;
                if (we) m_di = (rd_do & mask) | (din & ~mask);
            end
            if (k == clr_k) begin m_to = 0; m_lk = 0; m_ov = 0; end
            if (k == dn - 1) begin
                if (set_to) m_to = 1;
                if (set_lk) m_lk = 1;
            end
            if (k == ovr_k && k >= 1 && k < dn) m_ov = 1;
        end
        req_en = 0; clr_err = 0; drdy = 0; locked = 1; k_now = -1;
        set_idle_exp();
    endtask

    initial begin
        model_reset();
        #1 reset_n = 0;
        #2;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_den", 32'(den), 0);
        chk("reset_mmcm_rst", 32'(mmcm_rst), 0);
        chk("reset_errs", 32'({err_timeout, err_lock, err_overrun}), 0);
        @(posedge clk_usb); #1;
        @(posedge clk_usb); #1;
        reset_n = 1;
        set_idle_exp();
        chk_en = 1;
        idle(3, 0);

        // plain read, drdy three cycles after den
        done_seen_k = -1;
        run_txn(0, 7'h08, 16'h0000, 16'h0000, 16'h1041, 3, 0, 0, -1, -1, -1);
        chk("read_done_cycle", 32'(done_seen_k), 5);
        chk("read_rdata", 32'(rdata), 32'h1041);
        idle(2, 0);

        // masked RMW
        done_seen_k = -1;
        run_txn(1, 7'h09, 16'h00C3, 16'hFF00, 16'hAB55, 2, 3, 4, -1, -1, -1);
        chk("rmw_di", 32'(di), 32'hABC3);
        chk("rmw_done_cycle", 32'(done_seen_k), 13);
        idle(1, 0);

        // all-ones mask writes back the value read
        run_txn(1, 7'h0A, 16'h1234, 16'hFFFF, 16'h5A5A, 1, 1, 0, -1, -1, -1);
        chk("mask_ffff_di", 32'(di), 32'h5A5A);
        idle(1, 0);

        // drdy timeout, clr_err lands on the same cycle as the set
        done_seen_k = -1;
        run_txn(0, 7'h10, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, -1, 256, -1);
        chk("to_done_cycle", 32'(done_seen_k), 257);
        chk("to_err_timeout", 32'(err_timeout), 1);
        chk("to_busy_after", 32'(busy), 0);
        idle(2, 1);
        chk("to_cleared", 32'(err_timeout), 0);

        // overrun during RD_WAIT
        run_txn(0, 7'h11, 16'h0000, 16'h0000, 16'hC0DE, 5, 0, 0, 3, -1, -1);
        chk("ovr_flag", 32'(err_overrun), 1);
        chk("ovr_rdata", 32'(rdata), 32'hC0DE);
        idle(1, 1);

        // reset pulsed during WR_WAIT, then a normal read
        run_txn(1, 7'h12, 16'hFFFF, 16'h0000, 16'h0F0F, 2, 10, 0, -1, -1, 7);
        idle(2, 0);
        run_txn(0, 7'h13, 16'h0000, 16'h0000, 16'h7777, 2, 0, 0, -1, -1, -1);
        chk("post_rst_rdata", 32'(rdata), 32'h7777);
        idle(1, 0);

        // lock timeout with software reset held
        rst_hold = 1;
        idle(1, 0);
        done_seen_k = -1;
        run_txn(1, 7'h14, 16'h0001, 16'h0000, 16'h0000, 1, 1, 100000, -1, -1, -1);
        chk("lock_err", 32'(err_lock), 1);
        chk("lock_done_cycle", 32'(done_seen_k), 65540);
        chk("lock_hold_rst", 32'(mmcm_rst), 1);
        rst_hold = 0;
        idle(2, 1);

        for (int t = 0; t < 60; t++) begin
            logic [15:0] msk;
            int rn, wn;
            msk = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            rn  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
            wn  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
            rst_hold = ($urandom_range(0, 7) == 0);
            run_txn(1'($urandom), 7'($urandom), 16'($urandom), msk, 16'($urandom), rn, wn,
                    $urandom_range(0, 5),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : -1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1, -1);
            idle($urandom_range(0, 2), 0);
        end
        rst_hold = 0;
        idle(3, 0);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
